// File: rtl/product_accumulator.sv
// product_accumulator
// Takes 16-bit products from the multiplier over a valid/ready handshake.
// Sums a programmable-length burst of them into an ACC_W-bit accumulator.
// Presents the registered sum over a second valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for the first product of a burst; acc holds last sum
//   S_ACCUM | burst in progress; adding each accepted product
//   S_DONE  | burst sum presented on acc_out; waiting for acc_ready
module product_accumulator #(
   parameter int ACC_W = 20,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [15:0]      prod,
   input  logic             prod_valid,
   output logic             prod_ready,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             clear,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // burst_len of zero encodes the maximum burst length 2^LEN_W
   localparam logic [LEN_W:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};
   localparam logic [LEN_W:0] LEN_ONE = {{LEN_W{1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [LEN_W:0]   cnt;
   logic [LEN_W:0]   target;
   logic [LEN_W:0]   target_new;
   logic [LEN_W:0]   cnt_inc;
   logic [ACC_W:0]   sum;
   logic             ovf;
   logic             prod_xfer;
   logic             res_xfer;

   assign target_new = (burst_len == '0) ? LEN_MAX : {1'b0, burst_len};
   assign cnt_inc    = cnt + LEN_ONE;
   // The extra top bit of sum is the carry out of the accumulator.
   assign sum        = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, prod};
   assign prod_xfer  = prod_valid && prod_ready;
   assign res_xfer   = acc_valid && acc_ready;

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; clear overrides everything, including a pending result
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (prod_xfer) state_nxt = (target_new == LEN_ONE) ? S_DONE : S_ACCUM;
            S_ACCUM: if (prod_xfer && (cnt_inc == target)) state_nxt = S_DONE;
            S_DONE:  if (res_xfer) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Handshake and status outputs decoded from the state register
   always_comb begin
      prod_ready = (state != S_DONE) && !clear;
      acc_valid  = (state == S_DONE);
      busy       = (state != S_IDLE);
   end

   // Accumulator datapath: first product loads, later products add, DONE freezes
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         acc    <= '0;
         cnt    <= '0;
         target <= '0;
         ovf    <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (prod_xfer) begin
         if (state == S_IDLE) begin
            acc    <= {{(ACC_W - 16){1'b0}}, prod};
            cnt    <= LEN_ONE;
            target <= target_new;
            ovf    <= 1'b0;
         end else begin
            acc <= sum[ACC_W-1:0];
            cnt <= cnt_inc;
            ovf <= ovf | sum[ACC_W];
         end
      end
   end

   assign acc_out  = acc;
   assign overflow = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator.
// dut20 uses the default ACC_W=20 and dut16 uses ACC_W=16 for the wrap case.
// The two instances share all inputs except prod_valid.
module tb_product_accumulator;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [15:0] prod;
   logic        pv20, pv16;
   logic [3:0]  burst_len;
   logic        clear;
   logic        acc_ready;

   logic        pr20, av20, ov20, busy20;
   logic [19:0] acc20;
   logic        pr16, av16, ov16, busy16;
   logic [15:0] acc16;

   int n_vec = 0;
   int n_err = 0;
   int n_acc;

   always #5 clk = ~clk;

   product_accumulator #(.ACC_W(20), .LEN_W(4)) dut20 (
      .clk(clk), .n_rst(n_rst), .prod(prod), .prod_valid(pv20), .prod_ready(pr20),
      .burst_len(burst_len), .clear(clear), .acc_out(acc20), .acc_valid(av20),
      .acc_ready(acc_ready), .overflow(ov20), .busy(busy20)
   );

   product_accumulator #(.ACC_W(16), .LEN_W(4)) dut16 (
      .clk(clk), .n_rst(n_rst), .prod(prod), .prod_valid(pv16), .prod_ready(pr16),
      .burst_len(burst_len), .clear(clear), .acc_out(acc16), .acc_valid(av16),
      .acc_ready(acc_ready), .overflow(ov16), .busy(busy16)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      n_rst = 1'b0; prod = '0; pv20 = 1'b0; pv16 = 1'b0;
      burst_len = '0; clear = 1'b0; acc_ready = 1'b0;
      #12;
      chk("rst_acc",   32'(acc20), 0);
      chk("rst_valid", 32'(av20), 0);
      chk("rst_ovf",   32'(ov20), 0);
      chk("rst_busy",  32'(busy20), 0);
      chk("rst_ready", 32'(pr20), 1);
      n_rst = 1'b1;
      step();

      // burst of 4: 1+2+3+4 = 10
      burst_len = 4'd4; acc_ready = 1'b1; pv20 = 1'b1;
      prod = 16'd1; step();
      chk("b4_busy_first", 32'(busy20), 1);
      chk("b4_valid_early", 32'(av20), 0);
      prod = 16'd2; step();
      prod = 16'd3; step();
      prod = 16'd4; step();
      pv20 = 1'b0;
      chk("b4_valid", 32'(av20), 1);
      chk("b4_sum",   32'(acc20), 10);
      chk("b4_ovf",   32'(ov20), 0);
      chk("b4_ready_done", 32'(pr20), 0);
      step();
      chk("b4_valid_1cyc", 32'(av20), 0);
      chk("b4_idle", 32'(busy20), 0);
      chk("b4_hold", 32'(acc20), 10);

      // burst_len=0 -> 16 products of 65025; mid-burst burst_len change ignored
      burst_len = 4'd0; acc_ready = 1'b0; pv20 = 1'b1; prod = 16'd65025; n_acc = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 1) burst_len = 4'd2;
         #1;
         if (pr20 && pv20) n_acc++;
         step();
      end
      pv20 = 1'b0;
      chk("b16_count", 32'(n_acc), 16);
      chk("b16_sum",   32'(acc20), 1040400);
      chk("b16_ovf",   32'(ov20), 0);
      chk("b16_valid", 32'(av20), 1);
      acc_ready = 1'b1; step();
      chk("b16_xfer", 32'(av20), 0);

      // ACC_W=16 wrap: 0xFFFF + 0x0002 = 0x0001 with overflow
      burst_len = 4'd2; pv16 = 1'b1;
      prod = 16'hFFFF; step();
      prod = 16'h0002; step();
      pv16 = 1'b0;
      chk("w16_sum",   32'(acc16), 1);
      chk("w16_ovf",   32'(ov16), 1);
      chk("w16_valid", 32'(av16), 1);
      step();
      chk("w16_ovf_idle", 32'(ov16), 1);
      burst_len = 4'd1; pv16 = 1'b1; prod = 16'd5; step();
      pv16 = 1'b0;
      chk("w16_next_sum", 32'(acc16), 5);
      chk("w16_next_ovf", 32'(ov16), 0);
      step();

      // burst of 3 with bubbles, then result stalled 5 cycles
      burst_len = 4'd3; acc_ready = 1'b0;
      pv20 = 1'b1; prod = 16'd100; step();
      pv20 = 1'b0; prod = 16'd999; step();
      pv20 = 1'b1; prod = 16'd200; step();
      pv20 = 1'b0; step(); step();
      chk("bub_partial", 32'(acc20), 300);
      chk("bub_not_done", 32'(av20), 0);
      pv20 = 1'b1; prod = 16'd300; step();
      prod = 16'd999;
      chk("bub_sum", 32'(acc20), 600);
      for (int i = 0; i < 5; i++) begin
         chk("stall_ready", 32'(pr20), 0);
         chk("stall_acc",   32'(acc20), 600);
         chk("stall_valid", 32'(av20), 1);
         step();
      end
      pv20 = 1'b0; acc_ready = 1'b1; step();
      chk("stall_xfer", 32'(av20), 0);
      chk("stall_keep", 32'(acc20), 600);

      // clear after 2 of 4 products
      burst_len = 4'd4;
      pv20 = 1'b1; prod = 16'd5; step();
      prod = 16'd6; step();
      prod = 16'd50; clear = 1'b1; #1;
      chk("clr_ready", 32'(pr20), 0);
      step();
      clear = 1'b0;
      chk("clr_busy",  32'(busy20), 0);
      chk("clr_acc",   32'(acc20), 0);
      chk("clr_valid", 32'(av20), 0);
      burst_len = 4'd1; prod = 16'd7; step();
      pv20 = 1'b0;
      chk("after_clr_sum",   32'(acc20), 7);
      chk("after_clr_valid", 32'(av20), 1);
      step();

      // clear in DONE discards the result even with acc_ready high
      acc_ready = 1'b0; burst_len = 4'd1; pv20 = 1'b1; prod = 16'd9; step();
      pv20 = 1'b0;
      chk("dclr_pre", 32'(acc20), 9);
      clear = 1'b1; acc_ready = 1'b1; step();
      clear = 1'b0;
      chk("dclr_acc",   32'(acc20), 0);
      chk("dclr_valid", 32'(av20), 0);

      // async reset while in DONE
      acc_ready = 1'b0; burst_len = 4'd2; pv20 = 1'b1;
      prod = 16'd3; step();
      prod = 16'd4; step();
      pv20 = 1'b0;
      chk("ar_pre_sum", 32'(acc20), 7);
      #2 n_rst = 1'b0;
      #1;
      chk("ar_valid", 32'(av20), 0);
      chk("ar_busy",  32'(busy20), 0);
      chk("ar_ovf",   32'(ov20), 0);
      chk("ar_acc",   32'(acc20), 0);
      chk("ar_ready", 32'(pr20), 1);
      step();
      n_rst = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the 8-bit Wallace tree multiplier. It consumes the 16-bit product word through a valid/ready handshake and sums a programmable-length burst of products into a wider accumulator. It then presents the registered sum through a second valid/ready handshake. Together with the multiplier it forms a multiply-accumulate (dot-product) datapath for layout prototyping.

## Interface
- ACC_W, 20, accumulator/result width. Must be ≥16. Default 20 holds 16 × 255 × 255 = 1,040,400 without overflow.
- LEN_W, 4, width of burst_len. Burst length range is 1..2^LEN_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- prod  in  16  product word from the multiplier Out.
- prod_valid  in  1  prod is valid this cycle.
- prod_ready  out  1  block accepts prod this cycle.
- burst_len  in  LEN_W  number of products per burst. Sampled only on the first accepted product of a burst. Value 0 means 2^LEN_W.
- clear  in  1  synchronous abort/clear, highest priority.
- acc_out  out  ACC_W  registered accumulator value.
- acc_valid  out  1  acc_out holds a completed burst sum.
- acc_ready  in  1  downstream accepts acc_out.
- overflow  out  1  sticky: a carry out of bit ACC_W-1 occurred in the current/last burst.
- busy  out  1  a burst is in progress (state ≠ IDLE).

## Operation
- Transfer rules: a product transfer occurs when prod_valid && prod_ready. A result transfer occurs when acc_valid && acc_ready.
- prod_ready = (state ≠ DONE) && !clear. It is combinational from state and clear only, never from prod_valid.
- acc_valid = (state == DONE).
- Registers: acc (ACC_W), cnt (LEN_W+1), target (LEN_W+1), overflow, state.
- State IDLE:
  - On a product transfer: acc ← zero-extended prod; cnt ← 1; target ← (burst_len==0 ? 2^LEN_W : burst_len); overflow ← 0.
  - Next state: DONE if target==1, else ACCUM.
  - acc holds its last value while idle.
- State ACCUM:
  - On a product transfer: acc ← (acc + prod) mod 2^ACC_W; overflow ← overflow | carry; cnt ← cnt+1.
  - Next state: DONE when cnt+1 == target.
  - No transfer: all registers hold. Bubbles in prod_valid are allowed indefinitely.
- State DONE:
  - acc, overflow and target are frozen. prod_ready=0.
  - On a result transfer: next state IDLE; acc keeps its value.
  - acc_ready low: hold indefinitely.
- clear (any state): next state IDLE; acc ← 0; cnt ← 0; overflow ← 0. Any product presented that cycle is not accepted (prod_ready=0). A pending result in DONE is discarded even if acc_ready is high.
- Arithmetic: unsigned only. The sum wraps modulo 2^ACC_W. overflow is the only wrap indicator.

## Timing
- Reset values (asynchronous on n_rst low): state=IDLE, acc_out=0, acc_valid=0, overflow=0, busy=0, cnt=0, target=0. prod_ready=1 while clear is low.
- Reset mid-burst or in DONE: result lost; outputs take reset values immediately, without waiting for a clock edge.
- Throughput: one product per cycle in IDLE/ACCUM.
- Latency: acc_valid rises on the edge that accepts the N-th product, so it is visible the cycle after that product.
- Burst turnaround: the DONE→IDLE handshake cycle has prod_ready=0. Minimum period for an N-product burst with acc_ready tied high is N+1 cycles.
- acc_out, acc_valid and overflow are direct register outputs with no combinational path from inputs. prod_ready depends combinationally on clear.
- burst_len changes after the first product of a burst have no effect until the next burst.

## Test plan
- Reset then burst_len=4, products 1,2,3,4 back-to-back, acc_ready=1 → acc_valid high the cycle after the 4th transfer, acc_out=10, overflow=0. acc_valid is high for 1 cycle, then IDLE.
- burst_len=0 (16 products), each prod=65025 (255×255), default ACC_W → acc_out=1,040,400, overflow=0, exactly 16 transfers accepted.
- ACC_W=16 instance, burst_len=2, prod=0xFFFF then 0x0002 → acc_out=0x0001, overflow=1. The next burst clears overflow on its first product.
- burst_len=3 with prod_valid bubbles between products, and acc_ready held low 5 cycles after completion → prod_ready=0 and acc_out stable through the stall. The result transfers on the first acc_ready cycle.
- clear asserted after 2 of 4 products (prod_valid high that cycle) → that product is not accepted, state IDLE, acc_out=0. A following burst of 1 product with value 7 yields acc_out=7.
- n_rst pulsed low asynchronously while in DONE with acc_ready=0 → acc_valid, busy, overflow and acc_out drop to 0 before the next clock edge. prod_ready=1.
